// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the RV32M divide sequencer
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration (shift in dividend MSB, trial subtract)
module div_step import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_msb,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);
  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_diff;
  // keep the bit shifted out of rem so the compare stays exact for large divisors
  always_comb begin
    w_sh = {i_rem, i_msb};
    w_diff = w_sh - {1'b0, i_dvs};
    o_qbit = w_sh >= {1'b0, i_dvs};
    o_rem = o_qbit ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
  end
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M div/divu/rem/remu sequencer with pipeline stall; DIV_EARLY_OUT_EN enables early exit for trivial cases
module div_sequencer import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall_pipe,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(DIV_ITERS);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  div_state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem, r_dvd, r_dvs, r_a;
  logic [WIDTH-1:0] w_rem, w_q, w_r, w_a_mag, w_b_mag;
  logic r_sel_rem, r_qneg, r_rneg, r_b0, r_ovf;
  logic w_qbit, w_signed, w_b0, w_ovf, w_early, w_accept;
`ifdef DIV_EARLY_OUT_EN
  logic w_lt;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_msb (r_dvd[WIDTH-1]),
    .i_dvs (r_dvs),
    .o_rem (w_rem),
    .o_qbit(w_qbit)
  );

  // operand classification, sign magnitudes and corner-case fixup values
  always_comb begin
    w_signed = (op == DIV) || (op == REM);
    w_b0 = b == '0;
    w_ovf = w_signed && a == MIN && b == '1;
    w_a_mag = (w_signed && a[WIDTH-1]) ? -a : a;
    w_b_mag = (w_signed && b[WIDTH-1]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
    w_lt = !w_signed && a < b;
    w_early = w_b0 || w_ovf || w_lt;
`else
    w_early = 1'b0;
`endif
    w_accept = r_state == IDLE && start;
    w_q = r_b0 ? '1 : r_ovf ? MIN : r_qneg ? -r_dvd : r_dvd;
    w_r = r_b0 ? r_a : r_ovf ? '0 : r_rneg ? -r_rem : r_rem;
  end

  // next-state and handshake outputs
  always_comb begin
    w_next = r_state == IDLE ? (start ? (w_early ? FIXUP : CALC) : IDLE) :
             r_state == CALC ? (r_cnt == LAST ? FIXUP : CALC) :
             r_state == FIXUP ? DONE : IDLE;
    busy = r_state != IDLE;
    done = r_state == DONE;
    stall_pipe = w_accept || r_state == CALC || r_state == FIXUP;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  // operand capture, iteration datapath and result load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_a <= '0;
      r_sel_rem <= 1'b0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_b0 <= 1'b0;
      r_ovf <= 1'b0;
      result <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_rem <= w_early ? a : '0;
      r_dvd <= w_early ? '0 : w_a_mag;
      r_dvs <= w_b_mag;
      r_a <= a;
      r_sel_rem <= op[1];
      r_qneg <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_rneg <= w_signed && a[WIDTH-1];
      r_b0 <= w_b0;
      r_ovf <= w_ovf;
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_rem <= w_rem;
      r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
    end else if (r_state == FIXUP) begin
      result <= r_sel_rem ? w_r : w_q;
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed self-checking bench for div_sequencer (expects DIV_EARLY_OUT_EN to match the RTL build)
module tb_div_sequencer;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY = 2;
`else
  localparam int EARLY = 34;
`endif
  logic clk = 1'b0;
  logic rst, start, busy, stall_pipe, done;
  logic [1:0] op;
  logic [31:0] a, b, result;
  int pass_cnt = 0;
  int total = 0;

  typedef struct {
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] q;
    int          c;
  } vec_t;

  vec_t vecs [18] = '{
    '{2'b01, 32'd100, 32'd7, 32'd14, 34},
    '{2'b10, 32'd100, 32'd7, 32'd2, 34},
    '{2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34},
    '{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34},
    '{2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, EARLY},
    '{2'b11, 32'd5, 32'd0, 32'd5, EARLY},
    '{2'b00, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, EARLY},
    '{2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, EARLY},
    '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, EARLY},
    '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, EARLY},
    '{2'b01, 32'd3, 32'd10, 32'd0, EARLY},
    '{2'b11, 32'd3, 32'd10, 32'd3, EARLY},
    '{2'b00, 32'd3, 32'd10, 32'd0, 34},
    '{2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34},
    '{2'b11, 32'hFFFFFFFF, 32'd10, 32'd5, 34},
    '{2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34},
    '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 34},
    '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, EARLY}
  };

  div_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .stall_pipe(stall_pipe), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output logic s0);
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    #1 s0 = stall_pipe;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output logic [31:0] res, output int bad);
    cyc = -1;
    bad = 0;
    res = 'x;
    for (int c = 1; c <= 60 && cyc < 0; c++) begin
      @(negedge clk);
      if (done) begin
        cyc = c;
        res = result;
        if (stall_pipe !== 1'b0) bad++;
      end else if (stall_pipe !== 1'b1 || busy !== 1'b1) bad++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total++; if (stall_pipe !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall_pipe); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    total++; if (result !== 32'd0) $display("FAIL reset_result got %h exp 0", result); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_timing;
    logic s0;
    int cyc, bad;
    logic [31:0] res;
    issue(2'b01, 32'd100, 32'd7, s0);
    wait_done(cyc, res, bad);
    total++; if (s0 !== 1'b1) $display("FAIL timing_issue_stall got %b exp 1", s0); else pass_cnt++;
    total++; if (cyc != 34) $display("FAIL timing_done_cycle got %0d exp 34", cyc); else pass_cnt++;
    total++; if (res !== 32'd14) $display("FAIL timing_result got %h exp %h", res, 32'd14); else pass_cnt++;
    total++; if (bad != 0) $display("FAIL timing_stall_profile got %0d bad cycles exp 0", bad); else pass_cnt++;
    @(negedge clk);
    total++; if (result !== 32'd14 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL timing_hold got result=%h done=%b busy=%b exp 0000000e 0 0", result, done, busy); else pass_cnt++;
  endtask

  task automatic test_divide;
    logic s0;
    int cyc, bad;
    logic [31:0] res;
    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].x, vecs[i].y, s0);
      wait_done(cyc, res, bad);
      total++; if (res !== vecs[i].q) $display("FAIL vec%0d_result got %h exp %h", i, res, vecs[i].q); else pass_cnt++;
      total++; if (cyc != vecs[i].c) $display("FAIL vec%0d_cycle got %0d exp %0d", i, cyc, vecs[i].c); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    logic s0;
    int cyc = -1;
    int pulses = 0;
    logic [31:0] res = '0;
    issue(2'b01, 32'd100, 32'd7, s0);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 10) begin
        start = 1'b1;
        op = 2'b01;
        a = 32'd9;
        b = 32'd3;
      end
      if (c == 11) start = 1'b0;
      if (done) begin
        pulses++;
        if (cyc < 0) begin
          cyc = c;
          res = result;
        end
      end
    end
    total++; if (pulses != 1) $display("FAIL b2b_pulses got %0d exp 1", pulses); else pass_cnt++;
    total++; if (cyc != 34) $display("FAIL b2b_cycle got %0d exp 34", cyc); else pass_cnt++;
    total++; if (res !== 32'd14) $display("FAIL b2b_result got %h exp %h", res, 32'd14); else pass_cnt++;
    total++; if (result !== 32'd14) $display("FAIL b2b_held got %h exp %h", result, 32'd14); else pass_cnt++;
  endtask

  task automatic test_start_in_done;
    logic s0;
    int cyc, bad;
    logic [31:0] res;
    issue(2'b01, 32'd9, 32'd3, s0);
    wait_done(cyc, res, bad);
    start = 1'b1;
    op = 2'b01;
    a = 32'd100;
    b = 32'd7;
    #1;
    total++; if (stall_pipe !== 1'b0) $display("FAIL done_start_stall got %b exp 0", stall_pipe); else pass_cnt++;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL done_start_busy got %b exp 0", busy); else pass_cnt++;
    total++; if (result !== 32'd3) $display("FAIL done_start_result got %h exp %h", result, 32'd3); else pass_cnt++;
  endtask

  task automatic test_rst_mid;
    logic s0;
    int cyc, bad;
    int pulses = 0;
    logic [31:0] res;
    issue(2'b01, 32'd100, 32'd7, s0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", busy); else pass_cnt++;
    total++; if (stall_pipe !== 1'b0) $display("FAIL rst_mid_stall got %b exp 0", stall_pipe); else pass_cnt++;
    total++; if (result !== 32'd0) $display("FAIL rst_mid_result got %h exp 0", result); else pass_cnt++;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    total++; if (pulses != 0) $display("FAIL rst_mid_no_done got %0d pulses exp 0", pulses); else pass_cnt++;
    issue(2'b01, 32'd9, 32'd3, s0);
    wait_done(cyc, res, bad);
    total++; if (res !== 32'd3) $display("FAIL rst_mid_recover got %h exp %h", res, 32'd3); else pass_cnt++;
    total++; if (cyc != 34) $display("FAIL rst_mid_recover_cycle got %0d exp 34", cyc); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_divide();
    test_back_to_back();
    test_start_in_done();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
